// File: rtl/gpr_pkg.sv
// Shared types for the GPR writeback path: data width, register index and
// the {rd, data} writeback payload carried through the LSU result FIFO.
package gpr_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_GPR = 32;

  typedef logic [4:0] gpr_idx_t;

  typedef struct packed {
    gpr_idx_t          rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate count.
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output wb_req_t head_c,
  output logic    full_c,
  output logic    empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic          do_push_c;
  logic          do_pop_c;

  // Status flags and head entry from the current pointers.
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head_c  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next pointers and storage; pushes into a full FIFO are ignored.
  always_comb begin
    do_push_c = push && !full_c;
    do_pop_c  = pop && !empty_c;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    if (do_push_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_req;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless while empty so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter and load scoreboard for the GPR file write port.
// ALU results commit directly; LSU results queue in wb_fifo. The FIFO head
// wins only when the FIFO is full (anti-starvation) or the ALU is idle.
// Optional feature macro: GPR_WB_BYPASS_EN adds fwd_* ports and masks busy
// for the register currently being written.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned XLEN     = gpr_pkg::XLEN,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic             pend_set,
  input  logic [4:0]       pend_rd,
  input  logic [4:0]       chk_a,
  input  logic [4:0]       chk_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic             reg_wen,
  output logic [4:0]       reg_wnum,
  output logic [XLEN-1:0]  rwdata
`ifdef GPR_WB_BYPASS_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data
`endif
);

  wb_req_t              lsu_req_c;
  wb_req_t              alu_req_c;
  wb_req_t              head_c;
  wb_req_t              win_req_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;
  logic                 alu_fire_c;
  logic                 fifo_pop_c;
  logic                 commit_c;

  logic                 reg_wen_q,  reg_wen_d;
  gpr_idx_t             reg_wnum_q, reg_wnum_d;
  logic [XLEN-1:0]      rwdata_q,   rwdata_d;
  logic [NUM_GPR-1:0]   pend_q,     pend_d;

  assign lsu_req_c = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(
    .DEPTH    (LQ_DEPTH)
  ) u_lq (
    .clk      (clk),
    .rst      (rst),
    .push     (lsu_valid),
    .push_req (lsu_req_c),
    .pop      (fifo_pop_c),
    .head_c   (head_c),
    .full_c   (fifo_full_c),
    .empty_c  (fifo_empty_c)
  );

  // Pick one committer: full FIFO beats ALU, ALU beats a non-full FIFO.
  always_comb begin
    alu_req_c  = '{rd: alu_rd, data: alu_data};
    alu_fire_c = alu_valid && !fifo_full_c;
    fifo_pop_c = !fifo_empty_c && (fifo_full_c || !alu_valid);
    commit_c   = alu_fire_c || fifo_pop_c;
    win_req_c  = fifo_pop_c ? head_c : alu_req_c;
  end

  assign alu_ready = alu_fire_c;
  assign lsu_ready = !fifo_full_c;

  // Registered write port; x0 commits complete the handshake but never write.
  always_comb begin
    reg_wen_d  = commit_c && (win_req_c.rd != '0);
    reg_wnum_d = reg_wnum_q;
    rwdata_d   = rwdata_q;
    if (reg_wen_d) begin
      reg_wnum_d = win_req_c.rd;
      rwdata_d   = win_req_c.data;
    end
  end

  // Pending-load bits: FIFO commits clear, pend_set sets, set wins on a tie.
  always_comb begin
    pend_d = pend_q;
    if (fifo_pop_c) begin
      pend_d[head_c.rd] = 1'b0;
    end
    if (pend_set && (pend_rd != '0)) begin
      pend_d[pend_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wen_q  <= 1'b0;
      reg_wnum_q <= '0;
      rwdata_q   <= '0;
      pend_q     <= '0;
    end else begin
      reg_wen_q  <= reg_wen_d;
      reg_wnum_q <= reg_wnum_d;
      rwdata_q   <= rwdata_d;
      pend_q     <= pend_d;
    end
  end

  assign reg_wen  = reg_wen_q;
  assign reg_wnum = reg_wnum_q;
  assign rwdata   = rwdata_q;

`ifdef GPR_WB_BYPASS_EN
  assign fwd_valid = reg_wen_q;
  assign fwd_rd    = reg_wnum_q;
  assign fwd_data  = rwdata_q;

  // Busy lookup, masked when the operand is on the forwarding bus this cycle.
  always_comb begin
    busy_a = pend_q[chk_a] && (chk_a != '0) && !(reg_wen_q && (reg_wnum_q == chk_a));
    busy_b = pend_q[chk_b] && (chk_b != '0) && !(reg_wen_q && (reg_wnum_q == chk_b));
  end
`else
  // Busy lookup straight from the scoreboard; x0 is never busy.
  always_comb begin
    busy_a = pend_q[chk_a] && (chk_a != '0);
    busy_b = pend_q[chk_b] && (chk_b != '0);
  end
`endif

`ifndef SYNTHESIS
  // A load may only be issued to a register with no load in flight,
  // unless that register's load is committing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && pend_set && (pend_rd != '0) &&
        !(fifo_pop_c && (head_c.rd == pend_rd))) begin
      assert (!pend_q[pend_rd]);
    end
  end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: a table of per-cycle stimulus with expected
// handshake/busy values, and expected writebacks queued at drive time and
// popped one edge later when the registered write port updates.
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        pend_set;
  logic [4:0]  pend_rd;
  logic [4:0]  chk_a, chk_b;
  logic        busy_a, busy_b;
  logic        reg_wen;
  logic [4:0]  reg_wnum;
  logic [31:0] rwdata;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        ps;
    logic [4:0]  prd;
    logic [4:0]  ca;
    logic [4:0]  cb;
    logic        e_ar;
    logic        e_lr;
    logic        e_ba;
    logic        e_bb;
    logic        e_wen;
    logic [4:0]  e_wnum;
    logic [31:0] e_wd;
    logic        e_all;
  } vec_t;

  typedef struct {
    int          idx;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wd;
    logic        all;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  gpr_wb_arbiter #(
    .XLEN     (32),
    .LQ_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .pend_set  (pend_set),
    .pend_rd   (pend_rd),
    .chk_a     (chk_a),
    .chk_b     (chk_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .reg_wen   (reg_wen),
    .reg_wnum  (reg_wnum),
    .rwdata    (rwdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input int rst_i, input int av, input int ard, input logic [31:0] ad,
                              input int lv, input int lrd, input logic [31:0] ld,
                              input int ps, input int prd, input int ca, input int cb,
                              input int ear, input int elr, input int eba, input int ebb,
                              input int ewen, input int ewnum, input logic [31:0] ewd,
                              input int eall);
    vec_t v;
    v.rst = 1'(rst_i);  v.av = 1'(av);  v.ard = 5'(ard);  v.ad = ad;
    v.lv = 1'(lv);      v.lrd = 5'(lrd); v.ld = ld;
    v.ps = 1'(ps);      v.prd = 5'(prd); v.ca = 5'(ca);   v.cb = 5'(cb);
    v.e_ar = 1'(ear);   v.e_lr = 1'(elr); v.e_ba = 1'(eba); v.e_bb = 1'(ebb);
    v.e_wen = 1'(ewen); v.e_wnum = 5'(ewnum); v.e_wd = ewd; v.e_all = 1'(eall);
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s vec=%0d got=0x%08h want=0x%08h", nm, idx, act, exp_v);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    pend_set  = 1'b0; pend_rd = '0;
    chk_a     = '0;   chk_b = '0;
  endtask

  // One cycle: drive, check combinational outputs, queue and then check the write.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    pend_set = v.ps;  pend_rd = v.prd;
    chk_a = v.ca;     chk_b = v.cb;
    #1;
    check("alu_ready", idx, 32'(alu_ready), 32'(v.e_ar));
    check("lsu_ready", idx, 32'(lsu_ready), 32'(v.e_lr));
    check("busy_a",    idx, 32'(busy_a),    32'(v.e_ba));
    check("busy_b",    idx, 32'(busy_b),    32'(v.e_bb));
    e.idx = idx; e.wen = v.e_wen; e.wnum = v.e_wnum; e.wd = v.e_wd; e.all = v.e_all;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("reg_wen", e.idx, 32'(reg_wen), 32'(e.wen));
    if (e.wen || e.all) begin
      check("reg_wnum", e.idx, 32'(reg_wnum), 32'(e.wnum));
      check("rwdata",   e.idx, rwdata,        e.wd);
    end
  endtask

  initial begin
    // rst av ard ad | lv lrd ld | ps prd ca cb | ar lr ba bb | wen wnum wd all
    // idle after reset
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  0,31, 0,1,0,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  7,9,  0,1,0,0, 0,0,32'h0,1));
    // single ALU write
    vecs.push_back(mk(0,1,5,32'hDEADBEEF, 0,0,32'h0,    0,0,  0,0,  1,1,0,0, 1,5,32'hDEADBEEF,0));
    // load to x7: ALU wins the shared cycle, load follows, busy until after commit
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    1,7,  7,0,  0,1,0,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,1,3,32'h33,       1,7,32'h1234, 0,0,  7,0,  1,1,1,0, 1,3,32'h33,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  7,0,  0,1,1,0, 1,7,32'h1234,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  7,0,  0,1,0,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  0,0,  0,1,0,0, 0,7,32'h1234,1));
    // fill FIFO under continuous ALU traffic; full FIFO steals one cycle
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    1,10, 10,0, 0,1,0,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    1,11, 10,11,0,1,1,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'h101,      1,10,32'hA0,  0,0,  10,11,1,1,1,1, 1,1,32'h101,0));
    vecs.push_back(mk(0,1,2,32'h102,      1,11,32'hB0,  0,0,  10,11,1,1,1,1, 1,2,32'h102,0));
    vecs.push_back(mk(0,1,3,32'h103,      1,12,32'hC0,  0,0,  10,11,0,0,1,1, 1,10,32'hA0,0));
    vecs.push_back(mk(0,1,3,32'h103,      1,12,32'hC0,  0,0,  10,11,1,1,0,1, 1,3,32'h103,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  10,11,0,0,0,1, 1,11,32'hB0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  10,11,0,1,0,0, 1,12,32'hC0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  0,0,  0,1,0,0, 0,0,32'h0,0));
    // x0 results from both sources and a pend_set to x0
    vecs.push_back(mk(0,1,0,32'h55,       1,0,32'h66,   1,0,  0,0,  1,1,0,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  0,0,  0,1,0,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  0,0,  0,1,0,0, 0,0,32'h0,0));
    // reset with two queued loads and x9 pending
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    1,9,  9,0,  0,1,0,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,1,4,32'h44,       1,13,32'hD0,  0,0,  9,0,  1,1,1,0, 1,4,32'h44,0));
    vecs.push_back(mk(0,1,5,32'h45,       1,14,32'hE0,  0,0,  9,0,  1,1,1,0, 1,5,32'h45,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,    0,0,  9,0,  0,0,1,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  9,0,  0,1,0,0, 0,0,32'h0,1));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  9,0,  0,1,0,0, 0,0,32'h0,1));
    // re-issue a load to x15 in its commit cycle: set wins over clear
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    1,15, 15,0, 0,1,0,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        1,15,32'hF0,  0,0,  15,0, 0,1,1,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    1,15, 15,0, 0,1,1,0, 1,15,32'hF0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  15,0, 0,1,1,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        1,15,32'hF1,  0,0,  15,0, 0,1,1,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  15,0, 0,1,1,0, 1,15,32'hF1,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,    0,0,  15,0, 0,1,0,0, 0,0,32'h0,0));

    // Initial reset
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_reg_wen",   -1, 32'(reg_wen),   32'h0);
    check("rst_reg_wnum",  -1, 32'(reg_wnum),  32'h0);
    check("rst_rwdata",    -1, rwdata,         32'h0);
    check("rst_lsu_ready", -1, 32'(lsu_ready), 32'h1);
    check("rst_alu_ready", -1, 32'(alu_ready), 32'h0);
    for (int i = 0; i < 32; i++) begin
      chk_a = 5'(i);
      chk_b = 5'(31 - i);
      #1;
      check("rst_busy_a", i, 32'(busy_a), 32'h0);
      check("rst_busy_b", i, 32'(busy_b), 32'h0);
    end
    drive_idle();

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
